// File: rtl/inst_aligner.sv
// Instruction aligner: buffers word-aligned fetch beats as halfwords and presents
// one 16-bit compressed or 32-bit (possibly straddling) instruction per handshake.
module inst_aligner #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc,
   input  logic            fetch_valid,
   output logic            fetch_ready,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic [31:0]     fetch_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            out_is_rvc
);

   logic [15:0]     r_hq [4];
   logic [2:0]      r_count;
   logic [XLEN-1:0] r_head_pc;
   logic            r_drop_low;

   logic            w_is16;
   logic            w_accept_in;
   logic            w_accept_out;
   logic [1:0]      w_deq;
   logic [2:0]      w_base;
   logic [2:0]      w_count_next;
   logic [15:0]     w_hq_next [4];
   logic [XLEN-1:0] w_head_pc_next;

   assign w_is16       = (r_hq[0][1:0] != 2'b11);
   assign fetch_ready  = (r_count <= 3'd2);
   assign out_valid    = !flush_i && ((r_count >= 3'd1 && w_is16) || (r_count >= 3'd2 && !w_is16));
   assign out_is_rvc   = out_valid && w_is16;
   assign out_inst     = w_is16 ? {16'h0000, r_hq[0]} : {r_hq[1], r_hq[0]};
   assign out_pc       = r_head_pc;
   assign w_accept_in  = fetch_valid && fetch_ready && !flush_i;
   assign w_accept_out = out_valid && out_ready;
   assign w_deq        = !w_accept_out ? 2'd0 : (w_is16 ? 2'd1 : 2'd2);
   // New halfwords land right behind whatever survives this cycle's dequeue.
   assign w_base       = r_count - {1'b0, w_deq};
   assign w_count_next = w_base + (w_accept_in ? (r_drop_low ? 3'd1 : 3'd2) : 3'd0);

   always_comb begin
      w_hq_next = r_hq;
      if (w_deq == 2'd1) begin
         w_hq_next[0] = r_hq[1];
         w_hq_next[1] = r_hq[2];
         w_hq_next[2] = r_hq[3];
      end else if (w_deq == 2'd2) begin
         w_hq_next[0] = r_hq[2];
         w_hq_next[1] = r_hq[3];
      end
      if (w_accept_in) begin
         for (int i = 0; i < 4; i++) begin
            if (r_drop_low) begin
               if (3'(i) == w_base) w_hq_next[i] = fetch_data[31:16];
            end else begin
               if (3'(i) == w_base) w_hq_next[i] = fetch_data[15:0];
               else if (3'(i) == w_base + 3'd1) w_hq_next[i] = fetch_data[31:16];
            end
         end
      end
   end

   always_comb begin
      w_head_pc_next = r_head_pc;
      if (w_accept_in && r_count == 3'd0)
         w_head_pc_next = fetch_pc + (r_drop_low ? XLEN'(2) : XLEN'(0));
      else if (w_accept_out)
         w_head_pc_next = r_head_pc + XLEN'({w_deq, 1'b0});
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) r_hq[i] <= 16'h0000;
         r_count    <= 3'd0;
         r_head_pc  <= '0;
         r_drop_low <= 1'b0;
      end else if (flush_i) begin
         r_count    <= 3'd0;
         r_head_pc  <= flush_pc;
         r_drop_low <= flush_pc[1];
      end else begin
         r_hq      <= w_hq_next;
         r_count   <= w_count_next;
         r_head_pc <= w_head_pc_next;
         if (w_accept_in) r_drop_low <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_aligner.sv
// Directed self-checking bench for inst_aligner: one task per scenario,
// inputs driven at the falling edge and outputs sampled 1ns later.
module tb_inst_aligner;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        fetch_valid = 1'b0;
   logic        fetch_ready;
   logic [31:0] fetch_pc = '0;
   logic [31:0] fetch_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_is_rvc;

   int nVec = 0;
   int nMis = 0;

   inst_aligner #(.XLEN(32)) dut (
      .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .flush_pc(flush_pc),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .fetch_data(fetch_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_is_rvc(out_is_rvc)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic doReset();
      reset_n = 1'b0; flush_i = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic beat(input logic [31:0] pc, input logic [31:0] data);
      fetch_valid = 1'b1; fetch_pc = pc; fetch_data = data;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst, fetch_ready} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
         nMis++;
         $display("[TB] FAIL reset_state: got v=%b rvc=%b pc=%h inst=%h rdy=%b want 0 0 0 0 1",
                  out_valid, out_is_rvc, out_pc, out_inst, fetch_ready);
      end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_two_rvc();
      doReset();
      out_ready = 1'b1;
      beat(32'h100, 32'h4585_4505);
      #1;
      nVec++;
      if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL rvc_empty: got %b want 0", out_valid); end
      tick();
      fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h100, 32'h0000_4505}) begin
         nMis++; $display("[TB] FAIL rvc_first: got %b%b %h %h want 11 00000100 00004505", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h102, 32'h0000_4585}) begin
         nMis++; $display("[TB] FAIL rvc_second: got %b%b %h %h want 11 00000102 00004585", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
      #1;
      nVec++;
      if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL rvc_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_straddle();
      doReset();
      out_ready = 1'b1;
      beat(32'h100, 32'h0513_0001);
      tick();
      fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h100, 32'h0000_0001}) begin
         nMis++; $display("[TB] FAIL strad_rvc: got %b%b %h %h want 11 00000100 00000001", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
      #1;
      nVec++;
      if ({out_valid, fetch_ready} !== 2'b01) begin
         nMis++; $display("[TB] FAIL strad_wait: got v=%b rdy=%b want v=0 rdy=1", out_valid, fetch_ready);
      end
      beat(32'h104, 32'h4505_0015);
      tick();
      fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b10, 32'h102, 32'h0015_0513}) begin
         nMis++; $display("[TB] FAIL strad_32: got %b%b %h %h want 10 00000102 00150513", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h106, 32'h0000_4505}) begin
         nMis++; $display("[TB] FAIL strad_tail: got %b%b %h %h want 11 00000106 00004505", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
   endtask

   task automatic test_backpressure();
      doReset();
      out_ready = 1'b0;
      beat(32'h100, 32'h00A0_0093);
      tick();
      #1;
      nVec++;
      if ({fetch_ready, out_valid, out_is_rvc, out_pc, out_inst} !== {3'b110, 32'h100, 32'h00A0_0093}) begin
         nMis++; $display("[TB] FAIL bp_one: got rdy=%b %b%b %h %h want 1 10 00000100 00a00093", fetch_ready, out_valid, out_is_rvc, out_pc, out_inst);
      end
      beat(32'h104, 32'h00B0_0113);
      tick();
      fetch_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         nVec++;
         if ({fetch_ready, out_valid, out_is_rvc, out_pc, out_inst} !== {3'b010, 32'h100, 32'h00A0_0093}) begin
            nMis++; $display("[TB] FAIL bp_full%0d: got rdy=%b %b%b %h %h want 0 10 00000100 00a00093", k, fetch_ready, out_valid, out_is_rvc, out_pc, out_inst);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      nVec++;
      if ({fetch_ready, out_valid, out_is_rvc, out_pc, out_inst} !== {3'b110, 32'h104, 32'h00B0_0113}) begin
         nMis++; $display("[TB] FAIL bp_release: got rdy=%b %b%b %h %h want 1 10 00000104 00b00113", fetch_ready, out_valid, out_is_rvc, out_pc, out_inst);
      end
      out_ready = 1'b1;
      tick();
      #1;
      nVec++;
      if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL bp_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      doReset();
      beat(32'h100, 32'h0001_0001);
      tick();
      out_ready = 1'b1;
      beat(32'h104, 32'h0001_0001);
      tick();
      // Three halfwords now buffered; the beat offered alongside the flush must vanish.
      beat(32'h300, 32'hFFFF_FFFF);
      flush_i = 1'b1; flush_pc = 32'h202;
      #1;
      nVec++;
      if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL flush_cycle: got %b want 0", out_valid); end
      tick();
      flush_i = 1'b0; fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, fetch_ready} !== 2'b01) begin
         nMis++; $display("[TB] FAIL flush_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid, fetch_ready);
      end
      beat(32'h200, 32'h4585_4505);
      tick();
      fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h202, 32'h0000_4585}) begin
         nMis++; $display("[TB] FAIL flush_odd: got %b%b %h %h want 11 00000202 00004585", out_valid, out_is_rvc, out_pc, out_inst);
      end
      tick();
      #1;
      nVec++;
      if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL flush_drop: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      logic [31:0] expPc;
      doReset();
      out_ready = 1'b1;
      pc = 32'h400;
      expPc = 32'h400;
      beat(pc, 32'h0001_0001);
      tick();
      pc = pc + 32'd4;
      fetch_pc = pc;
      for (int k = 1; k <= 10; k++) begin
         #1;
         nVec++;
         if ({out_valid, out_is_rvc, out_pc, out_inst, fetch_ready} !== {2'b11, expPc, 32'h0000_0001, k[0]}) begin
            nMis++; $display("[TB] FAIL b2b_%0d: got %b%b %h %h rdy=%b want 11 %h 00000001 rdy=%b",
                             k, out_valid, out_is_rvc, out_pc, out_inst, fetch_ready, expPc, k[0]);
         end
         if (k[0]) pc = pc + 32'd4;
         tick();
         fetch_pc = pc;
         expPc = expPc + 32'd2;
      end
      fetch_valid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      doReset();
      beat(32'h100, 32'h0001_0001);
      tick();
      out_ready = 1'b1;
      beat(32'h104, 32'h0001_0001);
      tick();
      fetch_valid = 1'b0; out_ready = 1'b0;
      #2;
      nVec++;
      if ({out_valid, fetch_ready} !== 2'b10) begin
         nMis++; $display("[TB] FAIL ar_before: got v=%b rdy=%b want v=1 rdy=0", out_valid, fetch_ready);
      end
      reset_n = 1'b0;
      #1;
      nVec++;
      if ({out_valid, fetch_ready} !== 2'b01) begin
         nMis++; $display("[TB] FAIL ar_immediate: got v=%b rdy=%b want v=0 rdy=1", out_valid, fetch_ready);
      end
      tick();
      reset_n = 1'b1;
      beat(32'h500, 32'h0001_0001);
      tick();
      fetch_valid = 1'b0;
      #1;
      nVec++;
      if ({out_valid, out_is_rvc, out_pc, out_inst} !== {2'b11, 32'h500, 32'h0000_0001}) begin
         nMis++; $display("[TB] FAIL ar_after: got %b%b %h %h want 11 00000500 00000001", out_valid, out_is_rvc, out_pc, out_inst);
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_two_rvc();
      test_straddle();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/inst_aligner.md
# inst_aligner

Instruction aligner between the fetch unit and the compressed-instruction expander. It accepts word-aligned 32-bit fetch beats and buffers them as 16-bit halfwords. It presents one instruction per handshake with its PC: either a 16-bit compressed parcel or a 32-bit instruction that may straddle two fetch words. Compressed parcels go on to the RVC expander; full-width instructions bypass it.

## Interface
Parameters:
- XLEN, 32, width of all PC signals

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  redirect; clears all buffered state
- flush_pc  in  XLEN  redirect target, 2-byte aligned (bit 0 = 0)
- fetch_valid  in  1  fetch beat valid
- fetch_ready  out  1  aligner can accept a beat
- fetch_pc  in  XLEN  word-aligned address of fetch_data (bits 1:0 = 0)
- fetch_data  in  32  instruction word, little-endian halfwords
- out_valid  out  1  instruction available
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  address of presented instruction
- out_inst  out  32  instruction; {16'b0, parcel} when compressed
- out_is_rvc  out  1  presented instruction is 16-bit

## Operation
- State: halfword queue, depth 4 (hq[0] = head), count 0..4, head_pc register, drop_low flag.
- Fetch accept: fetch_valid && fetch_ready && !flush_i.
- fetch_ready = (count <= 2). It is derived only from registered count, with no combinational path from out_ready.
- Enqueue with drop_low = 0: append fetch_data[15:0] then fetch_data[31:16]; count += 2.
- Enqueue with drop_low = 1: append only fetch_data[31:16]; count += 1; drop_low cleared.
- head_pc loads on an accepted beat only when count == 0 before the edge:
  - fetch_pc + 2 if drop_low = 1
  - fetch_pc otherwise
- Instruction size: hq[0][1:0] != 2'b11 means 16-bit; otherwise 32-bit.
- out_valid = !flush_i && ((count >= 1 && 16-bit) || (count >= 2 && 32-bit)).
- Presented values:
  - out_inst = {hq[1], hq[0]} for a 32-bit instruction, {16'b0, hq[0]} for a 16-bit one.
  - out_is_rvc = 16-bit flag.
  - out_pc = head_pc.
  - When out_valid = 0, out_inst/out_pc/out_is_rvc are don't-care.
- Output accept (out_valid && out_ready):
  - Shift the queue by 1 (16-bit) or 2 (32-bit).
  - count decreases by the same amount.
  - head_pc += 2 or 4, modulo 2^XLEN.
- Simultaneous accept on both sides:
  - Dequeue applies first, then the new halfwords append behind the survivors.
  - count_next = count − deq + enq. This never exceeds 4 because enq requires count <= 2.
- The block does not check that fetch_pc is sequential. Upstream guarantees that beats after a flush start at flush_pc & ~3 and increment by 4.
- Flush:
  - At the edge with flush_i = 1: count = 0, drop_low = flush_pc[1], head_pc = flush_pc.
  - Any fetch beat or output handshake in that cycle is discarded and not counted.
  - A flush overrides all other updates.
- A 32-bit instruction with only its low half buffered (count == 1) waits; out_valid stays 0 until the next beat arrives.

## Timing
- Reset (asynchronous, immediate): count = 0, drop_low = 0, head_pc = 0, out_valid = 0, fetch_ready = 1, out_inst = 0, out_pc = 0, out_is_rvc = 0.
- Latency:
  - A beat accepted at edge N makes its first instruction visible (out_valid = 1) in the cycle after edge N.
  - A straddling 32-bit instruction becomes visible in the cycle after its second beat is accepted.
- Throughput: one instruction per cycle when no starvation occurs.
- Handshakes follow valid/ready rules:
  - out_valid/out_inst/out_pc stay stable while out_valid && !out_ready, unless flush_i is asserted.
  - Upstream holds its beat stable while fetch_valid && !fetch_ready.
- Reset asserted mid-operation drops all buffered halfwords. Deassertion is synchronized externally.

## Test plan
- Two compressed parcels: reset, fetch_pc = 0x100, fetch_data = 0x4585_4505, out_ready = 1 → two outputs:
  - out_inst 0x00004505, pc 0x100, is_rvc 1
  - out_inst 0x00004585, pc 0x102, is_rvc 1
- Straddle: beats 0x100: 0x0513_0001, 0x104: 0x4505_0015 → three outputs:
  - 0x00000001 @0x100, rvc
  - 0x00150513 @0x102, is_rvc 0
  - 0x00004505 @0x106, rvc
  - out_valid = 0 for the cycle between the two beats if the second beat is delayed.
- Backpressure: out_ready = 0, stream beats of 32-bit instructions → count 2 then 4, and fetch_ready = 0 after the second beat. Raising out_ready for one cycle leaves count = 2 and fetch_ready = 1; out_inst is stable throughout the stall.
- Flush to odd halfword: with 3 halfwords buffered, flush_i = 1, flush_pc = 0x202. Then beat 0x200: 0x4585_4505 → only 0x00004585 @0x202 is emitted. A beat offered in the flush cycle is dropped.
- Full throughput: continuous beats of 0x0001_0001 with out_ready = 1 → one rvc output per cycle, PCs incrementing by 2. The queue never overflows and fetch_ready toggles as required.
- Async reset mid-stream: assert reset_n = 0 between edges with count = 3 → out_valid = 0 and fetch_ready = 1 immediately. After release, the first new beat's PC is reported correctly.
